// File: rtl/reg_mem_ctrl.sv
// reg_mem_ctrl: single-outstanding request controller for the reg_mem register file.
// Host side is valid/ready request + valid/ready response. Memory side drives
// addr/data_in/wen and absorbs the memory's one-cycle registered read latency.
// All outputs come straight from flops.
// Optional build macro REG_MEM_CTRL_READBACK_VERIFY_EN: every write is read back
// and rsp_err_o flags a readback mismatch.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | req_ready_o high, waiting for a request
// ISSUE   | memory samples addr/data/wen on the next edge
// VERIFY  | (macro builds only) write readback read issued, wen low
// CAPTURE | mem_data_out_i valid; captured into rsp_rdata_o on next edge
// RESP    | rsp_valid_o high, holding until rsp_ready_i
module reg_mem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wen_i,
    input  logic [ADDR_BITS-1:0]  req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_in_o,
    output logic                  mem_wen_o,
    input  logic [DATA_WIDTH-1:0] mem_data_out_i,
    output logic [CNT_WIDTH-1:0]  txn_count_o
);

`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        VERIFY  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
    logic                    mem_wen_q, mem_wen_d;
    logic [CNT_WIDTH-1:0]    txn_count_q, txn_count_d;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
    logic                    is_wr_q, is_wr_d;
    logic                    rsp_err_q, rsp_err_d;
`endif

    // State and output registers; reset drops any in-flight transaction and wen at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_wen_q     <= 1'b0;
            txn_count_q   <= '0;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
            is_wr_q       <= 1'b0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wen_q     <= mem_wen_d;
            txn_count_q   <= txn_count_d;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
            is_wr_q       <= is_wr_d;
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_wen_d     = 1'b0;
        txn_count_d   = txn_count_q;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
        is_wr_d       = is_wr_q;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    mem_addr_d    = req_addr_i;
                    mem_data_in_d = req_wdata_i;
                    mem_wen_d     = req_wen_i;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
                    is_wr_d       = req_wen_i;
`endif
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_wen_q) begin
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
                    state_d     = VERIFY;
`else
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`endif
                end else begin
                    state_d = CAPTURE;
                end
            end
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
            VERIFY: begin
                state_d = CAPTURE;
            end
`endif
            CAPTURE: begin
                rsp_rdata_d = mem_data_out_i;
                rsp_valid_d = 1'b1;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
                rsp_err_d   = is_wr_q && (mem_data_out_i != mem_data_in_q);
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + CNT_ONE;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_in_o = mem_data_in_q;
    assign mem_wen_o     = mem_wen_q;
    assign txn_count_o   = txn_count_q;
`ifdef REG_MEM_CTRL_READBACK_VERIFY_EN
    assign rsp_err_o     = rsp_err_q;
`else
    assign rsp_err_o     = 1'b0;
`endif

endmodule
